// File: rtl/mod_counter_pkg.sv
// Shared lab package for the modulo counter: default sizes, direction encoding
// and a clog2 helper for sizing counters against a modulus.
package mod_counter_pkg;

   localparam int DEFAULT_WIDTH   = 4;
   localparam int DEFAULT_MODULUS = 16;
   localparam int DEFAULT_PRE_W   = 8;

   typedef enum logic {
      DIR_DOWN = 1'b0,
      DIR_UP   = 1'b1
   } dir_e;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'sd1 <<< i) < value) result = i + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/mod_counter_prescaler.sv
// Rate divider for mod_counter: asserts tick once every div+1 enabled cycles.
// Only instantiated when MOD_COUNTER_PRESCALE_EN is defined.
module mod_counter_prescaler #(
   parameter int PRE_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic [PRE_W-1:0] div,
   output logic             tick
);

   logic [PRE_W-1:0] cnt;
   logic             at_end;

   // ">=" rather than "==" so a div lowered below the running count wraps at once
   assign at_end = (cnt >= div);
   assign tick   = en & at_end;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         if (at_end) cnt <= '0;
         else        cnt <= cnt + PRE_W'(1);
      end
   end

endmodule

// File: rtl/mod_counter.sv
// Modulo-N up/down counter with clamped synchronous load and registered wrap pulse.
// Optional prescaler compiled in with MOD_COUNTER_PRESCALE_EN.
module mod_counter
   import mod_counter_pkg::*;
#(
   parameter int WIDTH   = DEFAULT_WIDTH,
   parameter int MODULUS = DEFAULT_MODULUS,
   parameter int PRE_W   = DEFAULT_PRE_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [PRE_W-1:0] div,
   output logic [WIDTH-1:0] a,
   output logic             tc
);

   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

   dir_e             dir;
   logic             tick;
   logic [WIDTH-1:0] load_clamped;

   assign dir = dir_e'(up);

   // One extra bit so MODULUS = 2^WIDTH never clamps
   assign load_clamped = ({1'b0, load_val} >= MOD_EXT) ? MAX_VAL : load_val;

`ifdef MOD_COUNTER_PRESCALE_EN
   mod_counter_prescaler #(
      .PRE_W (PRE_W)
   ) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .clr  (load),
      .div  (div),
      .tick (tick)
   );
`else
   logic unused_div;
   assign unused_div = ^div;
   assign tick       = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a  <= '0;
         tc <= 1'b0;
      end else if (load) begin
         a  <= load_clamped;
         tc <= 1'b0;
      end else if (en && tick) begin
         if (dir == DIR_UP) begin
            if (a == MAX_VAL) begin
               a  <= '0;
               tc <= 1'b1;
            end else begin
               a  <= a + ONE;
               tc <= 1'b0;
            end
         end else begin
            if (a == '0) begin
               a  <= MAX_VAL;
               tc <= 1'b1;
            end else begin
               a  <= a - ONE;
               tc <= 1'b0;
            end
         end
      end else begin
         tc <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mod_counter.sv
// Self-checking bench for mod_counter: MODULUS=10 and MODULUS=16 instances
// driven in parallel, directed table, hand sequences and random vs. model.
module tb_mod_counter;

   logic       clk;
   logic       rst;
   logic       en;
   logic       up;
   logic       load;
   logic [3:0] load_val;
   logic [7:0] div;
   logic [3:0] a10, a16;
   logic       tc10, tc16;

   int errors = 0;
   int checks = 0;

   int m10, m16;
   bit t10, t16;
`ifdef MOD_COUNTER_PRESCALE_EN
   int pc;
`endif

   mod_counter #(.WIDTH(4), .MODULUS(10), .PRE_W(8)) u10 (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
      .load_val(load_val), .div(div), .a(a10), .tc(tc10)
   );

   mod_counter #(.WIDTH(4), .MODULUS(16), .PRE_W(8)) u16 (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
      .load_val(load_val), .div(div), .a(a16), .tc(tc16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit       en;
      bit       up;
      bit       load;
      bit [3:0] lv;
      int       ea;
      bit       etc;
   } vec_t;

   vec_t tbl[$];

   task automatic check(input string nm, input logic [3:0] act_a, input int exp_a,
                        input logic act_tc, input bit exp_tc);
      checks++;
      if (act_a !== 4'(exp_a) || act_tc !== exp_tc) begin
         errors++;
         $display("FAIL %s: got a=%0d tc=%0b, expected a=%0d tc=%0b at t=%0t",
                  nm, act_a, act_tc, exp_a, exp_tc, $time);
      end
   endtask

   task automatic drive(input bit e, input bit u, input bit l, input bit [3:0] lv);
      en       = e;
      up       = u;
      load     = l;
      load_val = lv;
   endtask

   // Reference: value kept as an integer in 0..M-1, stepped with modular arithmetic
   task automatic model_one(inout int m, inout bit t, input int modv, input bit tick);
      t = 0;
      if (load) begin
         m = (int'(load_val) >= modv) ? modv - 1 : int'(load_val);
      end else if (en && tick) begin
         if (up) begin
            t = (m == modv - 1);
            m = (m + 1) % modv;
         end else begin
            t = (m == 0);
            m = (m + modv - 1) % modv;
         end
      end
   endtask

   task automatic model_edge();
      bit tick;
      tick = 1'b1;
`ifdef MOD_COUNTER_PRESCALE_EN
      tick = (pc >= int'(div));
`endif
      model_one(m10, t10, 10, tick);
      model_one(m16, t16, 16, tick);
`ifdef MOD_COUNTER_PRESCALE_EN
      if (load)    pc = 0;
      else if (en) pc = tick ? 0 : pc + 1;
`endif
   endtask

   task automatic model_reset();
      m10 = 0; m16 = 0; t10 = 0; t16 = 0;
`ifdef MOD_COUNTER_PRESCALE_EN
      pc = 0;
`endif
   endtask

   task automatic step(input string nm);
      @(posedge clk);
      model_edge();
      #1;
      check({nm, "_m10"}, a10, m10, tc10, t10);
      check({nm, "_m16"}, a16, m16, tc16, t16);
   endtask

   initial begin
      rst = 1'b0;
      div = 8'd0;
      drive(0, 1, 0, 4'd0);
      model_reset();

      #3;
      check("reset_m10", a10, 0, tc10, 1'b0);
      check("reset_m16", a16, 0, tc16, 1'b0);
      @(negedge clk);
      rst = 1'b1;

      // Directed table on the MODULUS=10 instance
      tbl.push_back('{1, 1, 1, 4'd5,  5, 0});
      tbl.push_back('{1, 1, 0, 4'd0,  6, 0});
      tbl.push_back('{0, 1, 1, 4'd12, 9, 0});
      tbl.push_back('{1, 1, 0, 4'd0,  0, 1});
      tbl.push_back('{0, 1, 1, 4'd9,  9, 0});
      tbl.push_back('{1, 1, 1, 4'd9,  9, 0});
      tbl.push_back('{0, 1, 0, 4'd0,  9, 0});
      tbl.push_back('{0, 0, 1, 4'd1,  1, 0});
      tbl.push_back('{1, 0, 0, 4'd0,  0, 0});
      tbl.push_back('{1, 0, 0, 4'd0,  9, 1});
      tbl.push_back('{1, 0, 0, 4'd0,  8, 0});
      tbl.push_back('{0, 1, 1, 4'd3,  3, 0});
      tbl.push_back('{0, 0, 0, 4'd0,  3, 0});
      tbl.push_back('{0, 1, 0, 4'd0,  3, 0});
      tbl.push_back('{0, 0, 0, 4'd0,  3, 0});
      tbl.push_back('{0, 1, 0, 4'd0,  3, 0});
      tbl.push_back('{0, 0, 0, 4'd0,  3, 0});
      tbl.push_back('{1, 1, 0, 4'd0,  4, 0});
      tbl.push_back('{1, 0, 0, 4'd0,  3, 0});
      tbl.push_back('{0, 0, 1, 4'd15, 9, 0});
      foreach (tbl[i]) begin
         drive(tbl[i].en, tbl[i].up, tbl[i].load, tbl[i].lv);
         step("tbl");
         check($sformatf("tbl%0d", i), a10, tbl[i].ea, tc10, tbl[i].etc);
      end

      // Asynchronous reset mid-count, right after a wrap pulse
      drive(0, 1, 1, 4'd8);
      step("pre_rst");
      drive(1, 1, 0, 4'd0);
      step("pre_rst");
      step("pre_rst");
      check("pre_rst_wrap", a10, 0, tc10, 1'b1);
      #2 rst = 1'b0;
      model_reset();
      #1;
      check("async_rst_m10", a10, 0, tc10, 1'b0);
      check("async_rst_m16", a16, 0, tc16, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step("post_rst");
         check($sformatf("post_rst%0d", i), a10, (i + 1) % 10, tc10, i == 9);
      end

      // Full-range natural wrap on the MODULUS=16 instance
      drive(0, 1, 1, 4'd15);
      step("full");
      drive(1, 1, 0, 4'd0);
      step("full");
      check("full_up_wrap", a16, 0, tc16, 1'b1);
      drive(1, 0, 0, 4'd0);
      step("full");
      check("full_dn_wrap", a16, 15, tc16, 1'b1);
      step("full");
      check("full_dn_next", a16, 14, tc16, 1'b0);

`ifdef MOD_COUNTER_PRESCALE_EN
      div = 8'd3;
      drive(0, 1, 1, 4'd0);
      step("pre");
      drive(1, 1, 0, 4'd0);
      for (int i = 0; i < 3; i++) begin
         step("pre");
         check("pre_wait", a10, 0, tc10, 1'b0);
      end
      step("pre");
      check("pre_tick", a10, 1, tc10, 1'b0);
      drive(0, 1, 1, 4'd9);
      step("pre");
      drive(1, 1, 0, 4'd0);
      for (int i = 0; i < 3; i++) step("pre");
      step("pre");
      check("pre_tc_on", a10, 0, tc10, 1'b1);
      step("pre");
      check("pre_tc_off", a10, 0, tc10, 1'b0);
      div = 8'd0;
      step("pre");
      check("pre_div0_a", a10, 1, tc10, 1'b0);
      step("pre");
      check("pre_div0_b", a10, 2, tc10, 1'b0);
`endif

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 9) == 0,
               4'($urandom));
`ifdef MOD_COUNTER_PRESCALE_EN
         if ($urandom_range(0, 15) == 0) div = 8'($urandom_range(0, 3));
`endif
         step("rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
